ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one single-port `ram` instance (registered read, 1-cycle latency, write has priority over read) between two requesters.
- Typical requesters: M0 is the CPU data port, M1 is the loader/debug port.
- Issues at most one RAM command per cycle and returns read data with a valid strobe.
- Supports locked multi-cycle ownership (read-modify-write), bounded by a hold counter.

Parameters:
- DATA_WIDTH, 32, data width of the RAM and both requester ports.
- ADDR_WIDTH, 8, address width of the RAM and both requester ports.
- MAX_HOLD, 8, maximum consecutive grants to one locked master while the other master is requesting (≥1).

Ports:
- i_clk  input  1  clock; everything on posedge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_m0_req  input  1  M0 command request; command fields are held stable until granted.
- i_m0_we  input  1  M0 write (1) / read (0).
- i_m0_lock  input  1  M0 requests to keep ownership after this grant.
- i_m0_addr  input  ADDR_WIDTH  M0 address.
- i_m0_wdata  input  DATA_WIDTH  M0 write data.
- o_m0_gnt  output  1  M0 command accepted this cycle (combinational).
- o_m0_rvalid  output  1  M0 read data valid (registered).
- o_m0_rdata  output  DATA_WIDTH  M0 read data.
- i_m1_* / o_m1_*  same set as M0, for requester M1.
- o_ram_we  output  1  to RAM i_we.
- o_ram_oe  output  1  to RAM i_oe.
- o_ram_addr  output  ADDR_WIDTH  to RAM i_addr.
- o_ram_data  output  DATA_WIDTH  to RAM i_data.
- i_ram_data  input  DATA_WIDTH  from RAM o_data.

Behaviour:
- Reset (async, i_rst_n=0):
  - State OPEN, owner=M0, hold_cnt=0, priority=M0.
  - o_m*_rvalid=0, o_m*_rdata=0.
  - o_ram_we=o_ram_oe=0 while in reset.
- Handshake: a command transfers in the cycle where req=1 and gnt=1. At most one gnt is high per cycle. gnt never asserts without req.
- RAM drive: in a granted cycle, drive o_ram_addr/o_ram_data from the winner, and set o_ram_we=we, o_ram_oe=~we. With no grant, o_ram_we=o_ram_oe=0 (the RAM holds its output).
- Read latency: a read granted in cycle N gives o_mX_rvalid=1 in cycle N+1, with o_mX_rdata = RAM output after edge N. o_mX_rdata holds its last value when rvalid=0.
- Back-to-back reads or mixed commands, one per cycle, are allowed with no bubbles.
- Writes produce no rvalid.
- States:
  - OPEN:
    - Only one master requesting → it wins.
    - Both requesting → the priority master wins (priority policy below).
    - Winner with lock=1 → go to LOCKED, owner=winner, hold_cnt=1.
  - LOCKED:
    - Only the owner may be granted.
    - Owner req with lock=1: grant; hold_cnt++ if the other master is requesting, else hold_cnt stays.
    - Owner req with lock=0: grant, go to OPEN (the final access of the locked sequence).
    - Owner req=0: no grant, stay LOCKED (the owner may idle). hold_cnt frees only on forced release.
    - Forced release: hold_cnt==MAX_HOLD and the other master is requesting → next cycle returns to OPEN, with that cycle's arbitration favouring the other master. The owner's lock is ignored on this forced grant: the owner's command in the release cycle is not granted.
  - hold_cnt saturates at MAX_HOLD and resets to 0 on entering OPEN.
- Reset mid-read: the pending rvalid is dropped; nothing is delivered after reset deasserts.

Optional Feature:
- Macro RAM_ARB_RR_EN.
- Defined: round-robin. After every OPEN-state grant, priority passes to the other master. A forced release also hands priority to the other master.
- Undefined: fixed priority, M0 always wins in OPEN. Forced release still grants M1 for exactly one arbitration.

Test Plan:
- M0 write addr 0x05 data 0xDEADBEEF, then M0 read 0x05 → gnt both cycles; o_m0_rvalid=1 one cycle after the read gnt with rdata 0xDEADBEEF; o_m1_rvalid stays 0.
- M0 and M1 both read continuously (M1 addr 0x10=0x11111111, M0 addr 0x20=0x22222222):
  - RR_EN → grants alternate M0,M1,M0…, and each rvalid carries its own data.
  - Fixed → M0 is granted every cycle and M1 never.
- M1 lock sequence: read 0x30 with lock=1, then write 0x30 with lock=0, while M0 requests → M0 gets no gnt until after M1's unlocked write, then M0 is granted the next cycle.
- MAX_HOLD=8, M0 holds lock=1 with req every cycle and M1 requesting → exactly 8 M0 grants, then M1 granted; hold_cnt back to 0.
- Read granted, then i_rst_n pulsed low before the next edge → no rvalid after reset, all outputs 0, state OPEN.
- Both masters idle → o_ram_we=o_ram_oe=0 and no gnt/rvalid for 10 cycles.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port registered-read RAM, with locked
// ownership bounded by MAX_HOLD. Define RAM_ARB_RR_EN for round-robin priority.

module ram_arb_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rvalid <= 1'b0;
      last     <= '0;
    end else begin
      o_rvalid <= i_rd;
      if (o_rvalid) last <= i_ram_data;
    end
  end

  // RAM output is live in the cycle after the read; keep it once rvalid drops.
  assign o_rdata = o_rvalid ? i_ram_data : last;
endmodule

module ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_m0_req,
  input  logic                  i_m0_we,
  input  logic                  i_m0_lock,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_wdata,
  output logic                  o_m0_gnt,
  output logic                  o_m0_rvalid,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  input  logic                  i_m1_req,
  input  logic                  i_m1_we,
  input  logic                  i_m1_lock,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_wdata,
  output logic                  o_m1_gnt,
  output logic                  o_m1_rvalid,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  output logic                  o_ram_we,
  output logic                  o_ram_oe,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {S_OPEN, S_LOCKED} state_t;

  logic [1:0]                 req, we, lock, gnt, rd, rvalid;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] wdata, rdata;

  state_t        state, nstate;
  logic          owner, nowner, favor, nfavor, win, other;
  logic [HW-1:0] hold_cnt, nhold;

  assign req   = {i_m1_req, i_m0_req};
  assign we    = {i_m1_we, i_m0_we};
  assign lock  = {i_m1_lock, i_m0_lock};
  assign addr  = {i_m1_addr, i_m0_addr};
  assign wdata = {i_m1_wdata, i_m0_wdata};
  assign other = ~owner;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_OPEN;
      owner    <= 1'b0;
      favor    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= nstate;
      owner    <= nowner;
      favor    <= nfavor;
      hold_cnt <= nhold;
    end
  end

  always_comb begin
    gnt    = '0;
    win    = 1'b0;
    nstate = state;
    nowner = owner;
    nfavor = favor;
    nhold  = hold_cnt;
    case (state)
      S_OPEN: begin
        if (req != 2'b00) begin
          win      = (req == 2'b11) ? favor : req[1];
          gnt[win] = 1'b1;
`ifdef RAM_ARB_RR_EN
          nfavor   = ~win;
`else
          nfavor   = 1'b0;
`endif
          if (lock[win]) begin
            nstate = S_LOCKED;
            nowner = win;
            nhold  = HW'(1);
          end
        end
      end
      S_LOCKED: begin
        // Forced release spends one idle cycle, then OPEN favours the waiter.
        if (hold_cnt == HW'(MAX_HOLD) && req[other]) begin
          nstate = S_OPEN;
          nhold  = '0;
          nfavor = other;
        end else if (req[owner]) begin
          win        = owner;
          gnt[owner] = 1'b1;
          if (!lock[owner]) begin
            nstate = S_OPEN;
            nhold  = '0;
          end else if (req[other] && hold_cnt < HW'(MAX_HOLD)) begin
            nhold = hold_cnt + HW'(1);
          end
        end
      end
      default: nstate = S_OPEN;
    endcase
    if (!i_rst_n) gnt = '0;
  end

  assign o_ram_we   = (|gnt) & we[win];
  assign o_ram_oe   = (|gnt) & ~we[win];
  assign o_ram_addr = addr[win];
  assign o_ram_data = wdata[win];
  assign rd         = gnt & ~we;

  for (genvar k = 0; k < 2; k++) begin : g_lane
    ram_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_rd       (rd[k]),
      .i_ram_data (i_ram_data),
      .o_rvalid   (rvalid[k]),
      .o_rdata    (rdata[k])
    );
  end

  assign o_m0_gnt    = gnt[0];
  assign o_m1_gnt    = gnt[1];
  assign o_m0_rvalid = rvalid[0];
  assign o_m1_rvalid = rvalid[1];
  assign o_m0_rdata  = rdata[0];
  assign o_m1_rdata  = rdata[1];
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM plus a cycle-level reference model of the
// arbitration rules, directed scenarios followed by random traffic.

module tb_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          rq[2], we[2], lk[2];
  logic [AW-1:0] ad[2];
  logic [DW-1:0] wd[2];

  logic          gnt0, gnt1, rv0, rv1, ram_we, ram_oe;
  logic [DW-1:0] rd0, rd1, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] mem [256] = '{default: '0};
  logic [DW-1:0] ram_q = '0;

  always @(posedge clk) begin
    if (ram_we)      mem[ram_addr] <= ram_wdata;
    else if (ram_oe) ram_q <= mem[ram_addr];
  end

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_req(rq[0]), .i_m0_we(we[0]), .i_m0_lock(lk[0]), .i_m0_addr(ad[0]), .i_m0_wdata(wd[0]),
    .o_m0_gnt(gnt0), .o_m0_rvalid(rv0), .o_m0_rdata(rd0),
    .i_m1_req(rq[1]), .i_m1_we(we[1]), .i_m1_lock(lk[1]), .i_m1_addr(ad[1]), .i_m1_wdata(wd[1]),
    .o_m1_gnt(gnt1), .o_m1_rvalid(rv1), .o_m1_rdata(rd1),
    .o_ram_we(ram_we), .o_ram_oe(ram_oe), .o_ram_addr(ram_addr), .o_ram_data(ram_wdata),
    .i_ram_data(ram_q)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  bit            ref_locked;
  int            ref_owner, ref_hold, ref_fav;
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  bit            exp_rv[2];
  logic [DW-1:0] exp_rd[2];
  int            last_w;
  logic          obs_g0, obs_g1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    ref_locked = 0; ref_owner = 0; ref_hold = 0; ref_fav = 0;
    exp_rv = '{0, 0}; exp_rd = '{'0, '0};
  endtask

  // One clock: predict grant from the arbitration rules, check, then advance.
  task automatic step(input string tag);
    int w, oth;
    bit rel;
    #1;
    w = -1; rel = 0; oth = 1 - ref_owner;
    if (!ref_locked) begin
      if (rq[0] && rq[1]) w = ref_fav;
      else if (rq[0])     w = 0;
      else if (rq[1])     w = 1;
    end else begin
      if (ref_hold == MH && rq[oth]) rel = 1;
      else if (rq[ref_owner])        w = ref_owner;
    end
    obs_g0 = gnt0; obs_g1 = gnt1;
    chk({tag, ".gnt0"}, gnt0, w == 0);
    chk({tag, ".gnt1"}, gnt1, w == 1);
    chk({tag, ".ram_we"}, ram_we, (w >= 0) && we[w]);
    chk({tag, ".ram_oe"}, ram_oe, (w >= 0) && !we[w]);
    if (w >= 0) begin
      chk({tag, ".ram_addr"}, ram_addr, ad[w]);
      if (we[w]) chk({tag, ".ram_data"}, ram_wdata, wd[w]);
    end
    chk({tag, ".rv0"}, rv0, exp_rv[0]);
    chk({tag, ".rv1"}, rv1, exp_rv[1]);
    chk({tag, ".rd0"}, rd0, exp_rd[0]);
    chk({tag, ".rd1"}, rd1, exp_rd[1]);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      exp_rv[k] = (w == k) && !we[k];
      if (exp_rv[k]) exp_rd[k] = ref_mem[ad[k]];
    end
    if (w >= 0 && we[w]) ref_mem[ad[w]] = wd[w];
    if (!ref_locked) begin
      if (w >= 0) begin
`ifdef RAM_ARB_RR_EN
        ref_fav = 1 - w;
`else
        ref_fav = 0;
`endif
        if (lk[w]) begin ref_locked = 1; ref_owner = w; ref_hold = 1; end
      end
    end else if (rel) begin
      ref_locked = 0; ref_hold = 0; ref_fav = oth;
    end else if (w >= 0) begin
      if (!lk[w]) begin ref_locked = 0; ref_hold = 0; end
      else if (rq[oth] && ref_hold < MH) ref_hold++;
    end
    last_w = w;
  endtask

  task automatic set_cmd(input int k, input logic r, input logic w_, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq[k] = r; we[k] = w_; lk[k] = l; ad[k] = a; wd[k] = d;
  endtask

  initial begin
    int n0;
    bit seen1;
    ref_reset();
    last_w = -1;
    set_cmd(0, 1, 0, 0, 8'h00, '0);
    set_cmd(1, 0, 0, 0, 8'h00, '0);
    rst_n = 0;
    #12;
    chk("rst.gnt0", gnt0, 0);
    chk("rst.gnt1", gnt1, 0);
    chk("rst.ram_we", ram_we, 0);
    chk("rst.ram_oe", ram_oe, 0);
    chk("rst.rv0", rv0, 0);
    chk("rst.rv1", rv1, 0);
    chk("rst.rd0", rd0, 0);
    chk("rst.rd1", rd1, 0);
    rq[0] = 0;
    @(posedge clk); #1;
    rst_n = 1;

    // M0 write then read back
    set_cmd(0, 1, 1, 0, 8'h05, 32'hDEADBEEF); step("wr05");
    set_cmd(0, 1, 0, 0, 8'h05, '0);           step("rd05");
    rq[0] = 0;                                step("rd05_ret");
    chk("rd05.rdata", rd0, 32'hDEADBEEF);

    // preload and contended continuous reads
    set_cmd(1, 1, 1, 0, 8'h10, 32'h11111111); step("pre10");
    rq[1] = 0;
    set_cmd(0, 1, 1, 0, 8'h20, 32'h22222222); step("pre20");
    set_cmd(0, 1, 0, 0, 8'h20, '0);
    set_cmd(1, 1, 0, 0, 8'h10, '0);
    for (int i = 0; i < 6; i++) step("both_rd");
    rq[0] = 0; rq[1] = 0;
    step("both_drain");

    // M1 locked read-modify-write while M0 waits
    set_cmd(1, 1, 0, 1, 8'h30, '0);           step("lk_rd30");
    set_cmd(1, 1, 1, 0, 8'h30, 32'hCAFEF00D);
    set_cmd(0, 1, 0, 0, 8'h20, '0);           step("lk_wr30");
    rq[1] = 0;                                step("lk_m0");
    rq[0] = 0;                                step("lk_idle");

    // M0 lock held against a requesting M1: forced release after MAX_HOLD grants
    n0 = 0; seen1 = 0;
    set_cmd(0, 1, 0, 1, 8'h20, '0);           step("hold_first");
    if (obs_g0) n0++;
    set_cmd(1, 1, 0, 0, 8'h10, '0);
    for (int i = 0; i < 14; i++) begin
      step("hold");
      if (obs_g1) begin seen1 = 1; rq[1] = 0; end
      else if (!seen1 && obs_g0) n0++;
    end
    chk("hold.m0_grants", n0, MH);
    chk("hold.m1_granted", seen1, 1);
    lk[0] = 0;                                step("hold_unlock");
    rq[0] = 0;                                step("hold_idle");

    // reset while a locked read's data is due
    set_cmd(0, 1, 0, 1, 8'h05, '0);           step("rst_rd");
    chk("rst_rd.rv_before", rv0, 1);
    rq[0] = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_mid.rv0", rv0, 0);
    chk("rst_mid.rd0", rd0, 0);
    chk("rst_mid.ram_oe", ram_oe, 0);
    #1 rst_n = 1;
    ref_reset();
    @(posedge clk); #1;
    step("rst_after");
    set_cmd(1, 1, 0, 0, 8'h30, '0);           step("rst_open_m1");
    rq[1] = 0;

    for (int i = 0; i < 10; i++) step("idle");

    // random traffic; a waiting command stays stable until granted
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(rq[k] && last_w != k))
          set_cmd(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), $urandom);
      end
      step("rand");
    end
    rq[0] = 0; rq[1] = 0;
    step("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
